fifo_rd_ctrl: RTL and testbench



---
 rtl/fifo_rd_ctrl.sv | 88 ++++++++
 tb/tb_fifo_rd_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the asynchronous FIFO.
// Keeps the binary read address and the Gray read pointer that feeds the
// write-domain synchroniser. It also produces a registered empty flag, an
// occupancy count, an almost-empty flag, a read-valid strobe aligned to the
// one-cycle RAM latency, and a sticky underflow flag.
module fifo_rd_ctrl #(
    parameter int ADDR_SIZE = 3
) (
    input  logic                 r_Clk,
    input  logic                 r_Rst,
    input  logic                 r_Inc,
    input  logic [ADDR_SIZE:0]   rsync_Wptr,
    input  logic [ADDR_SIZE:0]   r_AeThresh,
    input  logic                 r_ClrUnderflow,
    output logic [ADDR_SIZE-1:0] r_Addr,
    output logic [ADDR_SIZE:0]   r_Ptr,
    output logic                 fifo_Empty,
    output logic                 fifo_AlmostEmpty,
    output logic [ADDR_SIZE:0]   r_Count,
    output logic                 r_Valid,
    output logic                 r_Underflow
);

    logic [ADDR_SIZE:0] r_bin_reg;
    logic [ADDR_SIZE:0] r_bin_next;
    logic [ADDR_SIZE:0] r_gray_next;
    logic [ADDR_SIZE:0] w_bin;
    logic [ADDR_SIZE:0] cnt_next;
    logic               accept;

    // A request while empty is dropped so the pointer never passes the writer.
    assign accept      = r_Inc & ~fifo_Empty;
    assign r_bin_next  = r_bin_reg + {{ADDR_SIZE{1'b0}}, accept};
    assign r_gray_next = (r_bin_next >> 1) ^ r_bin_next;

    // Gray-to-binary of the synced write pointer: each binary bit is the XOR
    // of all Gray bits at or above it, written per bit to keep it a flat tree.
    generate
        for (genvar gi = 0; gi <= ADDR_SIZE; gi++) begin : g_w_bin
            assign w_bin[gi] = ^rsync_Wptr[ADDR_SIZE:gi];
        end
    endgenerate

    // Occupancy uses the post-read pointer so a read and a write in the same
    // cycle are both reflected. The synced write pointer lags, so this count
    // can only be low, never high.
    assign cnt_next = w_bin - r_bin_next;

    assign r_Addr = r_bin_reg[ADDR_SIZE-1:0];

    // Pointer state: binary address and Gray pointer advance together.
    always_ff @(posedge r_Clk or negedge r_Rst) begin
        if (!r_Rst) begin
            r_bin_reg <= '0;
            r_Ptr     <= '0;
        end else begin
            r_bin_reg <= r_bin_next;
            r_Ptr     <= r_gray_next;
        end
    end

    // Status flags computed from the next pointer, so draining the last word
    // raises empty at the same edge and back-to-back reads cannot over-read.
    always_ff @(posedge r_Clk or negedge r_Rst) begin
        if (!r_Rst) begin
            fifo_Empty       <= 1'b1;
            fifo_AlmostEmpty <= 1'b1;
            r_Count          <= '0;
        end else begin
            fifo_Empty       <= (r_gray_next == rsync_Wptr);
            fifo_AlmostEmpty <= (cnt_next <= r_AeThresh);
            r_Count          <= cnt_next;
        end
    end

    // Valid strobe trails the accepted read by one cycle to match RAM latency;
    // underflow is sticky, and a new underflow wins over a clear.
    always_ff @(posedge r_Clk or negedge r_Rst) begin
        if (!r_Rst) begin
            r_Valid     <= 1'b0;
            r_Underflow <= 1'b0;
        end else begin
            r_Valid     <= accept;
            r_Underflow <= (r_Inc & fifo_Empty) | (r_Underflow & ~r_ClrUnderflow);
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed testbench for fifo_rd_ctrl with ADDR_SIZE=3.
module tb_fifo_rd_ctrl;

    logic       r_Clk;
    logic       r_Rst;
    logic       r_Inc;
    logic [3:0] rsync_Wptr;
    logic [3:0] r_AeThresh;
    logic       r_ClrUnderflow;
    logic [2:0] r_Addr;
    logic [3:0] r_Ptr;
    logic       fifo_Empty;
    logic       fifo_AlmostEmpty;
    logic [3:0] r_Count;
    logic       r_Valid;
    logic       r_Underflow;

    logic clk_en;
    int   total;
    int   bad;

    fifo_rd_ctrl #(.ADDR_SIZE(3)) dut (
        .r_Clk           (r_Clk),
        .r_Rst           (r_Rst),
        .r_Inc           (r_Inc),
        .rsync_Wptr      (rsync_Wptr),
        .r_AeThresh      (r_AeThresh),
        .r_ClrUnderflow  (r_ClrUnderflow),
        .r_Addr          (r_Addr),
        .r_Ptr           (r_Ptr),
        .fifo_Empty      (fifo_Empty),
        .fifo_AlmostEmpty(fifo_AlmostEmpty),
        .r_Count         (r_Count),
        .r_Valid         (r_Valid),
        .r_Underflow     (r_Underflow)
    );

    // Gated clock so the reset test can run with no edges at all.
    always begin
        #5;
        if (clk_en) r_Clk = ~r_Clk;
    end

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge r_Clk);
        #1;
    endtask

    task automatic test_reset();
        r_Rst = 1'b1;
        #2;
        r_Rst = 1'b0;
        #2;
        total++;
        if (r_Addr !== 3'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", r_Addr); end
        total++;
        if (r_Ptr !== 4'd0) begin bad++; $display("FAIL reset_ptr got=%b exp=0000", r_Ptr); end
        total++;
        if (fifo_Empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", fifo_Empty); end
        total++;
        if (fifo_AlmostEmpty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b exp=1", fifo_AlmostEmpty); end
        total++;
        if (r_Count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", r_Count); end
        total++;
        if (r_Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", r_Valid); end
        total++;
        if (r_Underflow !== 1'b0) begin bad++; $display("FAIL reset_underflow got=%b exp=0", r_Underflow); end
        $display("reset: addr=%0d ptr=%b empty=%b ae=%b count=%0d", r_Addr, r_Ptr, fifo_Empty, fifo_AlmostEmpty, r_Count);
        r_Rst = 1'b1;
        #1;
        clk_en = 1'b1;
    endtask

    task automatic test_fill();
        r_AeThresh = 4'd2;
        rsync_Wptr = 4'b0010;
        step();
        $display("fill: wptr=%b count=%0d empty=%b ae=%b", rsync_Wptr, r_Count, fifo_Empty, fifo_AlmostEmpty);
        total++;
        if (fifo_Empty !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b exp=0", fifo_Empty); end
        total++;
        if (r_Count !== 4'd3) begin bad++; $display("FAIL fill_count got=%0d exp=3", r_Count); end
        total++;
        if (fifo_AlmostEmpty !== 1'b0) begin bad++; $display("FAIL fill_ae_thr2 got=%b exp=0", fifo_AlmostEmpty); end
        r_AeThresh = 4'd3;
        step();
        $display("fill: thresh=3 ae=%b", fifo_AlmostEmpty);
        total++;
        if (fifo_AlmostEmpty !== 1'b1) begin bad++; $display("FAIL fill_ae_thr3 got=%b exp=1", fifo_AlmostEmpty); end
        total++;
        if (r_Valid !== 1'b0) begin bad++; $display("FAIL fill_valid got=%b exp=0", r_Valid); end
    endtask

    task automatic test_drain();
        logic [2:0] exp_addr  [5] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
        logic [3:0] exp_count [5] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
        logic       exp_empty [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic       exp_valid [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       exp_uf    [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        r_Inc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            $display("drain[%0d]: addr=%0d count=%0d empty=%b valid=%b uf=%b", i, r_Addr, r_Count, fifo_Empty, r_Valid, r_Underflow);
            total++;
            if (r_Addr !== exp_addr[i]) begin bad++; $display("FAIL drain_addr[%0d] got=%0d exp=%0d", i, r_Addr, exp_addr[i]); end
            total++;
            if (r_Count !== exp_count[i]) begin bad++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, r_Count, exp_count[i]); end
            total++;
            if (fifo_Empty !== exp_empty[i]) begin bad++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, fifo_Empty, exp_empty[i]); end
            total++;
            if (r_Valid !== exp_valid[i]) begin bad++; $display("FAIL drain_valid[%0d] got=%b exp=%b", i, r_Valid, exp_valid[i]); end
            total++;
            if (r_Underflow !== exp_uf[i]) begin bad++; $display("FAIL drain_underflow[%0d] got=%b exp=%b", i, r_Underflow, exp_uf[i]); end
        end
        r_Inc = 1'b0;
    endtask

    task automatic test_underflow();
        // Clear the flag left from the drain.
        r_ClrUnderflow = 1'b1;
        step();
        r_ClrUnderflow = 1'b0;
        $display("underflow: clear uf=%b", r_Underflow);
        total++;
        if (r_Underflow !== 1'b0) begin bad++; $display("FAIL uf_clear1 got=%b exp=0", r_Underflow); end
        // Read while empty sets the flag and leaves the pointer alone.
        r_Inc = 1'b1;
        step();
        r_Inc = 1'b0;
        $display("underflow: read-empty uf=%b ptr=%b", r_Underflow, r_Ptr);
        total++;
        if (r_Underflow !== 1'b1) begin bad++; $display("FAIL uf_set got=%b exp=1", r_Underflow); end
        total++;
        if (r_Ptr !== 4'b0010) begin bad++; $display("FAIL uf_ptr got=%b exp=0010", r_Ptr); end
        total++;
        if (r_Valid !== 1'b0) begin bad++; $display("FAIL uf_valid got=%b exp=0", r_Valid); end
        // Set and clear together: set wins.
        r_Inc = 1'b1;
        r_ClrUnderflow = 1'b1;
        step();
        r_Inc = 1'b0;
        r_ClrUnderflow = 1'b0;
        $display("underflow: set+clear uf=%b", r_Underflow);
        total++;
        if (r_Underflow !== 1'b1) begin bad++; $display("FAIL uf_set_wins got=%b exp=1", r_Underflow); end
        // Clear alone.
        r_ClrUnderflow = 1'b1;
        step();
        r_ClrUnderflow = 1'b0;
        $display("underflow: clear uf=%b", r_Underflow);
        total++;
        if (r_Underflow !== 1'b0) begin bad++; $display("FAIL uf_clear2 got=%b exp=0", r_Underflow); end
        // Flag stays low with no activity.
        step();
        total++;
        if (r_Underflow !== 1'b0) begin bad++; $display("FAIL uf_hold got=%b exp=0", r_Underflow); end
    endtask

    task automatic drain8(input logic [3:0] exp_ptr, input string tag);
        r_Inc = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (r_Count !== 4'(7 - i)) begin bad++; $display("FAIL %s_count[%0d] got=%0d exp=%0d", tag, i, r_Count, 7 - i); end
        end
        r_Inc = 1'b0;
        $display("%s: after 8 reads ptr=%b addr=%0d empty=%b", tag, r_Ptr, r_Addr, fifo_Empty);
        total++;
        if (r_Ptr !== exp_ptr) begin bad++; $display("FAIL %s_ptr got=%b exp=%b", tag, r_Ptr, exp_ptr); end
        total++;
        if (r_Addr !== 3'd0) begin bad++; $display("FAIL %s_addr got=%0d exp=0", tag, r_Addr); end
        total++;
        if (fifo_Empty !== 1'b1) begin bad++; $display("FAIL %s_empty got=%b exp=1", tag, fifo_Empty); end
    endtask

    task automatic test_full_wrap();
        // Start from a clean pointer, reset applied between edges.
        rsync_Wptr = 4'b0000;
        r_Rst = 1'b0;
        #2;
        r_Rst = 1'b1;
        rsync_Wptr = 4'b1100;
        step();
        $display("wrap: wptr=%b count=%0d empty=%b", rsync_Wptr, r_Count, fifo_Empty);
        total++;
        if (r_Count !== 4'd8) begin bad++; $display("FAIL full1_count got=%0d exp=8", r_Count); end
        total++;
        if (fifo_Empty !== 1'b0) begin bad++; $display("FAIL full1_empty got=%b exp=0", fifo_Empty); end
        total++;
        if (fifo_AlmostEmpty !== 1'b0) begin bad++; $display("FAIL full1_ae got=%b exp=0", fifo_AlmostEmpty); end
        drain8(4'b1100, "wrap1");
        rsync_Wptr = 4'b0000;
        step();
        $display("wrap: wptr=%b count=%0d empty=%b", rsync_Wptr, r_Count, fifo_Empty);
        total++;
        if (r_Count !== 4'd8) begin bad++; $display("FAIL full2_count got=%0d exp=8", r_Count); end
        total++;
        if (fifo_Empty !== 1'b0) begin bad++; $display("FAIL full2_empty got=%b exp=0", fifo_Empty); end
        drain8(4'b0000, "wrap2");
    endtask

    task automatic test_back_to_back();
        // Count 1, then a read and a +1 write in the same cycle.
        rsync_Wptr = 4'b0001;
        step();
        total++;
        if (r_Count !== 4'd1) begin bad++; $display("FAIL b2b_pre_count got=%0d exp=1", r_Count); end
        r_Inc = 1'b1;
        rsync_Wptr = 4'b0011;
        step();
        r_Inc = 1'b0;
        $display("b2b: count=%0d empty=%b addr=%0d valid=%b", r_Count, fifo_Empty, r_Addr, r_Valid);
        total++;
        if (r_Count !== 4'd1) begin bad++; $display("FAIL b2b_count got=%0d exp=1", r_Count); end
        total++;
        if (fifo_Empty !== 1'b0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", fifo_Empty); end
        total++;
        if (r_Addr !== 3'd1) begin bad++; $display("FAIL b2b_addr got=%0d exp=1", r_Addr); end
        total++;
        if (r_Ptr !== 4'b0001) begin bad++; $display("FAIL b2b_ptr got=%b exp=0001", r_Ptr); end
    endtask

    task automatic test_reset_mid();
        rsync_Wptr = 4'b0000;
        r_Rst = 1'b0;
        #2;
        r_Rst = 1'b1;
        rsync_Wptr = 4'b0111;
        step();
        total++;
        if (r_Count !== 4'd5) begin bad++; $display("FAIL mid_pre_count got=%0d exp=5", r_Count); end
        r_Inc = 1'b1;
        step();
        // Now count=4, valid=1, addr=1; pull reset between edges.
        #2;
        r_Rst = 1'b0;
        #1;
        $display("reset_mid: addr=%0d ptr=%b count=%0d empty=%b valid=%b", r_Addr, r_Ptr, r_Count, fifo_Empty, r_Valid);
        total++;
        if (r_Addr !== 3'd0) begin bad++; $display("FAIL mid_addr got=%0d exp=0", r_Addr); end
        total++;
        if (r_Ptr !== 4'd0) begin bad++; $display("FAIL mid_ptr got=%b exp=0000", r_Ptr); end
        total++;
        if (r_Count !== 4'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", r_Count); end
        total++;
        if (fifo_Empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%b exp=1", fifo_Empty); end
        total++;
        if (fifo_AlmostEmpty !== 1'b1) begin bad++; $display("FAIL mid_ae got=%b exp=1", fifo_AlmostEmpty); end
        total++;
        if (r_Valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", r_Valid); end
        total++;
        if (r_Underflow !== 1'b0) begin bad++; $display("FAIL mid_underflow got=%b exp=0", r_Underflow); end
        rsync_Wptr = 4'b0000;
        #1;
        r_Rst = 1'b1;
        step();
        $display("reset_mid: after release empty=%b ptr=%b uf=%b", fifo_Empty, r_Ptr, r_Underflow);
        total++;
        if (fifo_Empty !== 1'b1) begin bad++; $display("FAIL mid_post_empty got=%b exp=1", fifo_Empty); end
        total++;
        if (r_Ptr !== 4'd0) begin bad++; $display("FAIL mid_post_ptr got=%b exp=0000", r_Ptr); end
        total++;
        if (r_Underflow !== 1'b1) begin bad++; $display("FAIL mid_post_underflow got=%b exp=1", r_Underflow); end
        r_Inc = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        clk_en         = 1'b0;
        r_Clk          = 1'b0;
        r_Rst          = 1'b1;
        r_Inc          = 1'b0;
        rsync_Wptr     = 4'b0000;
        r_AeThresh     = 4'd2;
        r_ClrUnderflow = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_underflow();
        test_full_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
